// File: rtl/router_pkg.sv
// Shared router definitions: flit layout, flow-control bit positions and the
// packet framing state type used by the channel input buffer.
package router_pkg;
  localparam int FLIT_W = 68;
  localparam int VALID  = 0;
  localparam int HEAD   = 1;
  localparam int TAIL   = 2;

  localparam int FC_CREDIT      = 0;
  localparam int FC_ALMOST_FULL = 1;

  typedef enum logic {
    FRAME_IDLE = 1'b0,
    FRAME_BODY = 1'b1
  } frame_state_e;
endpackage

// File: rtl/flit_fifo.sv
// Power-of-two flit FIFO with occupancy count. The caller never reads when empty
// and never writes when full unless it also reads in the same cycle.
module flit_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = FLIT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !rd_en)      count <= count + (AW+1)'(1);
      else if (rd_en && !wr_en) count <= count - (AW+1)'(1);
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
endmodule

// File: rtl/channel_input_buffer.sv
// Credit-based channel input buffer: queues valid flits, forwards them while
// downstream credits last, returns upstream credits and checks packet framing.
module channel_input_buffer
  import router_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int CREDITS_INIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLIT_W-1:0] channel_in_ip,
  input  logic [1:0]        flow_ctrl_in_op,
  output logic [FLIT_W-1:0] channel_out_op,
  output logic [1:0]        flow_ctrl_out_ip,
  output logic              error
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CREDITS_INIT + 1);

  logic [FLIT_W-1:0] head_flit;
  logic [FLIT_W-1:0] send_flit;
  logic [AW:0]       count;
  logic [AW:0]       occ_next;
  logic              full;
  logic              empty;
  logic              wr_en;
  logic              deq;
  logic              drop;
  logic              credit_in;
  logic              credit_ovf;
  logic              frame_err;
  logic              deq_d;
  logic [CW-1:0]     credit_cnt;
  frame_state_e      state_q;
  frame_state_e      state_d;
  logic              unused_fc;

  assign unused_fc  = flow_ctrl_in_op[1];
  assign credit_in  = flow_ctrl_in_op[FC_CREDIT];
  assign deq        = !empty && (credit_cnt != '0);
  // A full FIFO still takes a flit when the head leaves in the same cycle.
  assign wr_en      = channel_in_ip[VALID] && (!full || deq);
  assign drop       = channel_in_ip[VALID] && full && !deq;
  assign credit_ovf = credit_in && !deq && (credit_cnt == CW'(CREDITS_INIT));

  flit_fifo #(.DEPTH(DEPTH), .W(FLIT_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (channel_in_ip),
    .rd_en   (deq),
    .rd_data (head_flit),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    occ_next = count;
    if (wr_en && !deq)      occ_next = count + (AW+1)'(1);
    else if (deq && !wr_en) occ_next = count - (AW+1)'(1);
    send_flit        = head_flit;
    send_flit[VALID] = 1'b1;
  end

  // Framing FSM advances only on flits that actually enter the FIFO.
  always_comb begin
    state_d   = state_q;
    frame_err = 1'b0;
    if (wr_en) begin
      case (state_q)
        FRAME_IDLE: begin
          if (!channel_in_ip[HEAD])     frame_err = 1'b1;
          else if (!channel_in_ip[TAIL]) state_d  = FRAME_BODY;
        end
        FRAME_BODY: begin
          if (channel_in_ip[HEAD]) begin
            frame_err = 1'b1;
            state_d   = channel_in_ip[TAIL] ? FRAME_IDLE : FRAME_BODY;
          end else if (channel_in_ip[TAIL]) begin
            state_d = FRAME_IDLE;
          end
        end
        default: state_d = FRAME_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= FRAME_IDLE;
      credit_cnt       <= CW'(CREDITS_INIT);
      channel_out_op   <= '0;
      flow_ctrl_out_ip <= '0;
      deq_d            <= 1'b0;
      error            <= 1'b0;
    end else begin
      state_q        <= state_d;
      channel_out_op <= deq ? send_flit : '0;
      if (deq && !credit_in)                                credit_cnt <= credit_cnt - CW'(1);
      else if (credit_in && !deq && (credit_cnt != CW'(CREDITS_INIT))) credit_cnt <= credit_cnt + CW'(1);
      // Upstream credit goes out the cycle after the flit appears downstream.
      deq_d                            <= deq;
      flow_ctrl_out_ip[FC_CREDIT]      <= deq_d;
      flow_ctrl_out_ip[FC_ALMOST_FULL] <= (occ_next >= (AW+1)'(DEPTH - 1));
      error <= error || drop || credit_ovf || frame_err;
    end
  end
endmodule
